// File: rtl/frame_src_pkg.sv
// Shared definitions for the frame source scheduler: source encodings,
// the scheduler state enum and small source-index helpers.
package frame_src_pkg;

   localparam int N_SRC = 5;

   localparam logic [2:0] SRC_VGA    = 3'd0;
   localparam logic [2:0] SRC_STATIC = 3'd1;
   localparam logic [2:0] SRC_G1     = 3'd2;
   localparam logic [2:0] SRC_G2     = 3'd3;
   localparam logic [2:0] SRC_DOG    = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // One-hot start vector for a source index; invalid indices give all zeros.
   function automatic logic [N_SRC-1:0] src_onehot(input logic [2:0] s);
      src_onehot = '0;
      if (s <= SRC_DOG) src_onehot[s] = 1'b1;
   endfunction

   // Round-robin successor, wrapping DoG back to VGA.
   function automatic logic [2:0] src_next(input logic [2:0] s);
      return (s == SRC_DOG) ? SRC_VGA : s + 3'd1;
   endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Stall counter: counts enabled cycles since the last clear and flags
// expiry on the cycle the count would reach LIMIT. A clear in the same
// cycle suppresses expiry, so progress always beats the abort.
module frame_watchdog #(
   parameter int LIMIT = 1048576
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   assign o_expire = i_enable && !i_clear && (r_cnt == CW'(LIMIT - 1));

   // Stall count: cleared on progress/state entry, advanced while armed.
   always_ff @(posedge i_clock) begin
      if (!i_reset)                   r_cnt <= '0;
      else if (i_clear)               r_cnt <= '0;
      else if (i_enable && !o_expire) r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/frame_source_scheduler.sv
// Frame-locked video source selector. The source is latched only when a
// frame starts, the start/start_ack handshake is run toward that source,
// its pixels are forwarded with one register stage until N_PIXEL have
// passed, and stalled frames are aborted with a sticky error flag.
// Handshake: o_frame_start_ack and o_frame_done are single-cycle pulses;
// o_src_start is a level held until the selected source acks; pixels are
// accepted on src_valid of the active source with no backpressure.
module frame_source_scheduler
   import frame_src_pkg::*;
#(
   parameter int N_PIXEL      = 480000,
   parameter int DWELL_FRAMES = 4,
   parameter int TIMEOUT      = 1048576
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [2:0]  i_sel_cfg,
   input  logic        i_auto_cycle,
   input  logic        i_frame_start,
   output logic        o_frame_start_ack,
   output logic [4:0]  o_src_start,
   input  logic [4:0]  i_src_start_ack,
   input  logic [4:0]  i_src_valid,
   input  logic [39:0] i_src_pixel,
   output logic [7:0]  o_pix_out,
   output logic        o_pix_valid,
   output logic [2:0]  o_active_src,
   output logic        o_frame_done,
   output logic        o_timeout_err,
   output logic [1:0]  o_dbg_state
);

   localparam int PCW = $clog2(N_PIXEL + 1);
   localparam int DCW = $clog2(DWELL_FRAMES + 1);

   state_e         r_state,       w_state_nxt;
   logic [2:0]     r_active_src,  w_active_nxt;
   logic [2:0]     r_rr_src,      w_rr_nxt;
   logic [DCW-1:0] r_dwell_cnt,   w_dwell_nxt;
   logic [PCW-1:0] r_pix_cnt,     w_pix_cnt_nxt;
   logic [4:0]     r_src_start,   w_src_start_nxt;
   logic           r_fsa,         w_fsa_nxt;
   logic [7:0]     r_pix_out,     w_pix_out_nxt;
   logic           r_pix_valid,   w_pix_valid_nxt;
   logic           r_frame_done,  w_done_nxt;
   logic           r_timeout_err, w_terr_nxt;
   logic           r_frame_auto,  w_frame_auto_nxt;

   logic           w_ack_hit;
   logic           w_pix_accept;
   logic [7:0]     w_pixel;
   logic [PCW-1:0] w_pix_cnt_inc;
   logic           w_wd_clear;
   logic           w_wd_enable;
   logic           w_expire;

   assign w_ack_hit     = i_src_start_ack[r_active_src];
   assign w_pixel       = i_src_pixel[{r_active_src, 3'b000} +: 8];
   assign w_pix_accept  = (r_state == ST_STREAM) && i_src_valid[r_active_src];
   assign w_pix_cnt_inc = r_pix_cnt + 1'b1;

   // Every state entry is either from IDLE/DONE or caused by an ack or a
   // pixel, so clearing on those conditions covers "clear on entry".
   assign w_wd_clear  = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                        ((r_state == ST_REQ) && w_ack_hit) || w_pix_accept;
   assign w_wd_enable = (r_state == ST_REQ) || (r_state == ST_STREAM);

   frame_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_watchdog (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (w_wd_clear),
      .i_enable (w_wd_enable),
      .o_expire (w_expire)
   );

   // Next-state and next-output decode for the frame FSM.
   always_comb begin
      w_state_nxt      = r_state;
      w_active_nxt     = r_active_src;
      w_rr_nxt         = r_rr_src;
      w_dwell_nxt      = r_dwell_cnt;
      w_pix_cnt_nxt    = r_pix_cnt;
      w_src_start_nxt  = r_src_start;
      w_fsa_nxt        = 1'b0;
      w_pix_out_nxt    = r_pix_out;
      w_pix_valid_nxt  = 1'b0;
      w_done_nxt       = 1'b0;
      w_terr_nxt       = r_timeout_err;
      w_frame_auto_nxt = r_frame_auto;
      case (r_state)
         ST_IDLE: begin
            w_src_start_nxt = '0;
            if (i_frame_start) begin
               w_state_nxt      = ST_REQ;
               w_frame_auto_nxt = i_auto_cycle;
               if (i_auto_cycle)            w_active_nxt = r_rr_src;
               else if (i_sel_cfg <= SRC_DOG) w_active_nxt = i_sel_cfg;
            end
         end
         ST_REQ: begin
            if (w_ack_hit) begin
               w_fsa_nxt       = 1'b1;
               w_src_start_nxt = '0;
               w_pix_cnt_nxt   = '0;
               w_state_nxt     = ST_STREAM;
            end else if (w_expire) begin
               w_terr_nxt      = 1'b1;
               w_src_start_nxt = '0;
               w_state_nxt     = ST_IDLE;
            end else begin
               w_src_start_nxt = src_onehot(r_active_src);
            end
         end
         ST_STREAM: begin
            if (w_pix_accept) begin
               w_pix_valid_nxt = 1'b1;
               w_pix_out_nxt   = w_pixel;
               w_pix_cnt_nxt   = w_pix_cnt_inc;
               if (w_pix_cnt_inc == PCW'(N_PIXEL)) w_state_nxt = ST_DONE;
            end else if (w_expire) begin
               w_terr_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
            if (r_frame_auto) begin
               if (r_dwell_cnt == DCW'(DWELL_FRAMES - 1)) begin
                  w_dwell_nxt = '0;
                  w_rr_nxt    = src_next(r_rr_src);
               end else begin
                  w_dwell_nxt = r_dwell_cnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and registered-output update with synchronous active-low reset.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state       <= ST_IDLE;
         r_active_src  <= SRC_VGA;
         r_rr_src      <= SRC_VGA;
         r_dwell_cnt   <= '0;
         r_pix_cnt     <= '0;
         r_src_start   <= '0;
         r_fsa         <= 1'b0;
         r_pix_out     <= '0;
         r_pix_valid   <= 1'b0;
         r_frame_done  <= 1'b0;
         r_timeout_err <= 1'b0;
         r_frame_auto  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_active_src  <= w_active_nxt;
         r_rr_src      <= w_rr_nxt;
         r_dwell_cnt   <= w_dwell_nxt;
         r_pix_cnt     <= w_pix_cnt_nxt;
         r_src_start   <= w_src_start_nxt;
         r_fsa         <= w_fsa_nxt;
         r_pix_out     <= w_pix_out_nxt;
         r_pix_valid   <= w_pix_valid_nxt;
         r_frame_done  <= w_done_nxt;
         r_timeout_err <= w_terr_nxt;
         r_frame_auto  <= w_frame_auto_nxt;
      end
   end

   assign o_frame_start_ack = r_fsa;
   assign o_src_start       = r_src_start;
   assign o_pix_out         = r_pix_out;
   assign o_pix_valid       = r_pix_valid;
   assign o_active_src      = r_active_src;
   assign o_frame_done      = r_frame_done;
   assign o_timeout_err     = r_timeout_err;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_frame_source_scheduler.sv
// Bench for frame_source_scheduler with N_PIXEL=16, DWELL_FRAMES=2,
// TIMEOUT=64. A frame-level model predicts the source of every frame and
// the pixel stream; a negedge compare process checks forwarded pixels.
module tb_frame_source_scheduler;

   localparam int NP = 16;
   localparam int DW = 2;
   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  sel_cfg;
   logic        auto_cycle;
   logic        frame_start;
   logic [4:0]  src_start_ack;
   logic [4:0]  src_valid;
   logic [39:0] src_pixel;
   logic        o_frame_start_ack;
   logic [4:0]  o_src_start;
   logic [7:0]  o_pix_out;
   logic        o_pix_valid;
   logic [2:0]  o_active_src;
   logic        o_frame_done;
   logic        o_timeout_err;
   logic [1:0]  o_dbg_state;

   frame_source_scheduler #(
      .N_PIXEL      (NP),
      .DWELL_FRAMES (DW),
      .TIMEOUT      (TO)
   ) dut (
      .i_clock           (clk),
      .i_reset           (rst_n),
      .i_sel_cfg         (sel_cfg),
      .i_auto_cycle      (auto_cycle),
      .i_frame_start     (frame_start),
      .o_frame_start_ack (o_frame_start_ack),
      .o_src_start       (o_src_start),
      .i_src_start_ack   (src_start_ack),
      .i_src_valid       (src_valid),
      .i_src_pixel       (src_pixel),
      .o_pix_out         (o_pix_out),
      .o_pix_valid       (o_pix_valid),
      .o_active_src      (o_active_src),
      .o_frame_done      (o_frame_done),
      .o_timeout_err     (o_timeout_err),
      .o_dbg_state       (o_dbg_state)
   );

   // Clock generation.
   always #5 clk = ~clk;

   int         n_pass  = 0;
   int         n_total = 0;
   logic       chk_en  = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] cmp_e;
   int         fsa_cnt  = 0;
   int         done_cnt = 0;

   // Frame-level model state.
   logic [2:0] m_rr      = 3'd0;
   logic [2:0] m_active  = 3'd0;
   logic [2:0] m_exp_src = 3'd0;
   int         m_dwell   = 0;
   logic       m_auto    = 1'b0;
   logic       m_terr    = 1'b0;

   logic [2:0] auto_seq [12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2,
                                 3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   function automatic logic [4:0] onehot(input logic [2:0] s);
      logic [4:0] v;
      v = 5'd1 << s;
      return v;
   endfunction

   function automatic logic [2:0] model_pick(input logic a, input logic [2:0] sel);
      if (a)             return m_rr;
      else if (sel <= 4) return sel;
      else               return m_active;
   endfunction

   task automatic model_frame_done();
      if (m_auto) begin
         m_dwell++;
         if (m_dwell == DW) begin
            m_dwell = 0;
            m_rr    = 3'((int'(m_rr) + 1) % 5);
         end
      end
   endtask

   task automatic model_reset();
      m_rr = 3'd0; m_active = 3'd0; m_dwell = 0; m_terr = 1'b0;
      exp_q.delete();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Random activity on every source except the active one.
   task automatic noise(input logic [2:0] s);
      src_valid     = 5'($urandom_range(0, 31)) & ~onehot(s);
      src_start_ack = 5'($urandom_range(0, 31)) & ~onehot(s);
      src_pixel     = {8'($urandom), 32'($urandom)};
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fsa"},   o_frame_start_ack, 0);
      check({tag, "_start"}, o_src_start, 0);
      check({tag, "_pix"},   o_pix_out, 0);
      check({tag, "_pv"},    o_pix_valid, 0);
      check({tag, "_src"},   o_active_src, 0);
      check({tag, "_done"},  o_frame_done, 0);
      check({tag, "_terr"},  o_timeout_err, 0);
      check({tag, "_state"}, o_dbg_state, 0);
   endtask

   // Compare process: forwarded pixels and start vector against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         if (o_frame_start_ack) fsa_cnt++;
         if (o_frame_done) done_cnt++;
         if (o_pix_valid) begin
            if (exp_q.size() == 0) begin
               check("pix_extra", 1, 0);
            end else begin
               cmp_e = exp_q.pop_front();
               check("pix_data", o_pix_out, cmp_e);
               check("pix_src", o_active_src, m_exp_src);
            end
         end
         if (o_src_start != 5'd0) check("src_onehot", o_src_start, onehot(m_exp_src));
      end
   end

   task automatic run_frame(input logic a, input logic [2:0] sel, input int ack_dly,
                            input int gap_max, input int last_gap,
                            input logic [2:0] sel_mid, input int rst_at);
      logic [2:0] s;
      logic [7:0] px;
      int         f0, d0, gap;
      auto_cycle = a;
      sel_cfg    = sel;
      s = model_pick(a, sel);
      m_active = s; m_exp_src = s; m_auto = a;
      f0 = fsa_cnt; d0 = done_cnt;
      frame_start = 1'b1;
      noise(s);
      step();
      check("start_early", o_src_start, 0);
      step();
      check("start_lat", o_src_start, onehot(s));
      repeat (ack_dly) begin noise(s); step(); end
      noise(s);
      src_start_ack[s] = 1'b1;
      step();
      check("ack_pulse", o_frame_start_ack, 1);
      check("start_drop", o_src_start, 0);
      frame_start = 1'b0;
      for (int i = 0; i < NP; i++) begin
         gap = (i == NP - 1) ? last_gap : $urandom_range(0, gap_max);
         repeat (gap) begin noise(s); step(); end
         if (i == NP / 2) sel_cfg = sel_mid;
         noise(s);
         src_valid[s] = 1'b1;
         px = 8'($urandom);
         src_pixel[8*s +: 8] = px;
         exp_q.push_back(px);
         step();
         if (i + 1 == rst_at) begin
            rst_n = 1'b0;
            noise(s);
            src_valid[s] = 1'b1;
            step();
            check_all_zero("midrst");
            rst_n = 1'b1;
            model_reset();
            return;
         end
      end
      check("done_early", o_frame_done, 0);
      noise(s);
      src_valid[s] = 1'b1;
      src_pixel[8*s +: 8] = 8'($urandom);
      step();
      check("done_lat", o_frame_done, 1);
      check("drop_in_done", o_pix_valid, 0);
      noise(s);
      step();
      check("done_pulse", o_frame_done, 0);
      model_frame_done();
      check("fsa_count", fsa_cnt - f0, 1);
      check("done_count", done_cnt - d0, 1);
      check("q_empty", exp_q.size(), 0);
      check("frame_src", o_active_src, s);
      check("terr_level", o_timeout_err, m_terr);
      check("idle_after", o_dbg_state, 0);
   endtask

   task automatic run_timeout(input logic a, input logic [2:0] sel);
      logic [2:0] s;
      int         f0;
      auto_cycle = a;
      sel_cfg    = sel;
      s = model_pick(a, sel);
      m_active = s; m_exp_src = s; m_auto = a;
      f0 = fsa_cnt;
      frame_start = 1'b1;
      noise(s);
      step();
      for (int k = 1; k < TO; k++) begin noise(s); step(); end
      check("to_early", o_timeout_err, m_terr);
      check("to_start_held", o_src_start, onehot(s));
      frame_start = 1'b0;
      noise(s);
      step();
      check("to_flag", o_timeout_err, 1);
      check("to_start_drop", o_src_start, 0);
      check("to_idle", o_dbg_state, 0);
      check("to_no_ack", fsa_cnt - f0, 0);
      m_terr = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; sel_cfg = 3'd0; auto_cycle = 1'b0; frame_start = 1'b0;
      src_start_ack = '0; src_valid = '0; src_pixel = '0;
      chk_en = 1'b1;
      repeat (3) step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Manual source 3, ack after 5 cycles, last pixel on the watchdog edge,
      // sel_cfg moved to 1 mid-stream.
      run_frame(1'b0, 3'd3, 5, 0, TO - 1, 3'd1, -1);
      check("manual_src3", o_active_src, 3);
      check("last_pix_no_err", o_timeout_err, 0);
      run_frame(1'b0, 3'd1, 2, 2, 0, 3'd1, -1);
      check("manual_src1", o_active_src, 1);
      run_frame(1'b0, 3'd2, 0, 1, 1, 3'd2, -1);
      run_frame(1'b0, 3'd6, 1, 1, 0, 3'd6, -1);
      check("invalid_keeps2", o_active_src, 2);

      // Auto round-robin from a fresh reset.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      model_reset();
      step();
      for (int k = 0; k < 12; k++) begin
         run_frame(1'b1, 3'($urandom_range(0, 7)), $urandom_range(0, 3), 2, 1, 3'd0, -1);
         check("auto_seq", o_active_src, auto_seq[k]);
      end

      // Aborted auto frame does not count toward dwell.
      run_frame(1'b1, 3'd0, 1, 1, 0, 3'd0, -1);
      check("auto_pre_abort", o_active_src, 1);
      run_timeout(1'b1, 3'd0);
      check("abort_src", o_active_src, 1);
      run_frame(1'b1, 3'd0, 1, 1, 0, 3'd0, -1);
      check("auto_post_abort", o_active_src, 1);
      run_frame(1'b1, 3'd0, 0, 1, 0, 3'd0, -1);
      check("auto_advance", o_active_src, 2);
      check("terr_sticky", o_timeout_err, 1);

      // Reset at pixel 7, then a complete frame from pixel 0.
      run_frame(1'b0, 3'd4, 1, 1, 0, 3'd4, 7);
      step();
      check("terr_cleared", o_timeout_err, 0);
      run_frame(1'b0, 3'd4, 1, 1, 0, 3'd4, -1);
      check("restart_src", o_active_src, 4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
